pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 163 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush, hold and a saturating back-pressure counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned        DATA_W   = 32,
  parameter int unsigned        CTRL_W   = 8,
  parameter logic [CTRL_W-1:0]  CTRL_RST = {CTRL_W{1'b1}},
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              hold,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_full;
  logic              up_xfer;

  // Hold masks the output without disturbing the stored entry.
  assign out_valid = out_full && !hold;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;
  assign stall_cnt = cnt_q;
  assign up_xfer   = in_valid && in_ready;

  always_comb begin
    cnt_d = cnt_q;
    if (!flush && !hold && out_full && !out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {StEmpty, StFull, StSkid} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              ready_q, ready_d;

  assign out_full = (state_q != StEmpty);
  assign in_ready = ready_q && resetn && !hold && !flush;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    ctrl_d      = ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = StEmpty;
      data_d      = '0;
      ctrl_d      = CTRL_RST;
      skid_data_d = '0;
      skid_ctrl_d = CTRL_RST;
    end else if (!hold) begin
      unique case (state_q)
        StEmpty: begin
          if (up_xfer) begin
            data_d  = in_data;
            ctrl_d  = in_ctrl;
            state_d = StFull;
          end
        end
        StFull: begin
          if (up_xfer && out_ready) begin
            data_d = in_data;
            ctrl_d = in_ctrl;
          end else if (up_xfer) begin
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
            state_d     = StSkid;
          end else if (out_ready) begin
            state_d = StEmpty;
          end
        end
        StSkid: begin
          if (out_ready) begin
            data_d  = skid_data_q;
            ctrl_d  = skid_ctrl_q;
            state_d = StFull;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    ready_d = (state_d != StSkid);
  end

  // ready_q resets high; in_ready is still held low by resetn while in reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StEmpty;
      ready_q     <= 1'b1;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_RST;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end
`else
  logic valid_q, valid_d;
  logic dn_xfer;

  assign out_full = valid_q;
  assign dn_xfer  = out_valid && out_ready;
  assign in_ready = (!valid_q || out_ready) && resetn && !hold && !flush;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      ctrl_d  = CTRL_RST;
    end else if (!hold) begin
      if (up_xfer) begin
        valid_d = 1'b1;
        data_d  = in_data;
        ctrl_d  = in_ctrl;
      end else if (dn_xfer) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_q <= '0;
      ctrl_q <= CTRL_RST;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; works with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

  localparam int unsigned       DW = 16;
  localparam int unsigned       CW = 4;
  localparam int unsigned       NW = 4;
  localparam logic [CW-1:0]     CR = 4'hF;
`ifdef PIPE_STAGE_SKID_EN
  localparam logic              SK = 1'b1;
`else
  localparam logic              SK = 1'b0;
`endif

  typedef logic [CW+DW-1:0] item_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          hold, flush;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [NW-1:0] stall_cnt;

  item_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W  (DW),
    .CTRL_W  (CW),
    .CTRL_RST(CR),
    .CNT_W   (NW)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .hold     (hold),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every downstream transfer must match the oldest expected item.
  always @(negedge clk) begin
    item_t e;
    if (resetn && out_valid && out_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got %0h, expected nothing", {out_ctrl, out_data});
      end else begin
        e = exp_q.pop_front();
        if ({out_ctrl, out_data} !== e) begin
          n_err++;
          $display("FAIL output_item: got %0h, expected %0h", {out_ctrl, out_data}, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic exp_rdy,
                      input string name);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
    #1;
    check(name, in_ready, exp_rdy);
    if (exp_rdy) exp_q.push_back({c, d});
  endtask

  task automatic apply_reset();
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    hold      = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    tick();
    tick();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; in_valid = 1'b1; in_data = 16'h99; in_ctrl = 4'h3;
    hold = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_ctrl", out_ctrl, CR);
    check("rst_out_data", out_data, 0);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_in_ready", in_ready, 0);
    in_valid = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    check("ready_after_release", in_ready, 1);

    // Streaming, one item per cycle
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(DW'(i), CW'(i), 1'b1, "stream_ready");
      check("stream_out_valid", out_valid, (i > 1) ? 1 : 0);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("stream_last_valid", out_valid, 1);
    tick();
    check("stream_empty", out_valid, 0);
    check("stream_drained", exp_q.size(), 0);

    // Back-pressure
    apply_reset();
    send(16'hA, 4'h1, 1'b1, "bp_ready_a");
    tick();
    send(16'hB, 4'h2, SK, "bp_ready_b");
    tick();
    in_valid = 1'b0;
    #1;
    check("bp_ready_low", in_ready, 0);
    repeat (4) tick();
    check("bp_stall_cnt", stall_cnt, 5);
    out_ready = 1'b1;
    tick();
    tick();
`ifndef PIPE_STAGE_SKID_EN
    send(16'hB, 4'h2, 1'b1, "bp_resend_b");
    tick();
    in_valid = 1'b0;
    tick();
`endif
    check("bp_stall_kept", stall_cnt, 5);
    check("bp_drained", exp_q.size(), 0);

    // Flush with entries held and a same-cycle input
    apply_reset();
    send(16'h1, 4'h1, 1'b1, "fl_ready_1");
    tick();
    send(16'h2, 4'h2, SK, "fl_ready_2");
    tick();
    flush = 1'b1;
    send(16'hC, 4'hC, 1'b0, "fl_blocks_input");
    exp_q.delete();
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_out_valid", out_valid, 0);
    check("fl_out_ctrl", out_ctrl, CR);
    check("fl_out_data", out_data, 0);
    check("fl_keeps_stall", stall_cnt, 1);
    out_ready = 1'b1;
    repeat (3) tick();
    check("fl_still_empty", out_valid, 0);

    // Hold freezes the stage
    apply_reset();
    send(16'h55, 4'h5, 1'b1, "hold_ready");
    tick();
    hold = 1'b1; in_valid = 1'b1; in_data = 16'h66; in_ctrl = 4'h6;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 0);
      check("hold_stall_cnt", stall_cnt, 0);
      tick();
    end
    hold = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("hold_release_valid", out_valid, 1);
    tick();
    check("hold_stall_after", stall_cnt, 0);
    check("hold_drained", exp_q.size(), 0);

    // Reset in the middle of a transfer
    apply_reset();
    send(16'h33, 4'h3, 1'b1, "mid_ready");
    tick();
    in_data = 16'h44; in_ctrl = 4'h4;
    #2;
    resetn = 1'b0;
    exp_q.delete();
    #1;
    check("mid_out_valid", out_valid, 0);
    check("mid_out_data", out_data, 0);
    in_valid = 1'b0;
    tick();
    resetn    = 1'b1;
    out_ready = 1'b1;
    repeat (2) tick();
    check("mid_nothing_out", out_valid, 0);

    // Stall counter saturation
    apply_reset();
    send(16'h7, 4'h7, 1'b1, "sat_ready");
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    check("sat_below", stall_cnt, 14);
    repeat (6) tick();
    check("sat_cap", stall_cnt, 15);
    out_ready = 1'b1;
    tick();
    check("sat_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
